// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the memory hierarchy, including the L2 port arbiter.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cacheline;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D
    } lc3b_arb_state;

    typedef enum logic {
        ARB_OWNER_I,
        ARB_OWNER_D
    } lc3b_arb_owner;

endpackage

// File: rtl/l2_arbiter_control.sv
// Arbitration FSM for the L2 port: round-robin grant, completion routing and conflict pulse.
module l2_arbiter_control
    import lc3b_types::*;
#(
    parameter bit D_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_pend,
    input  logic          d_pend,
    input  logic          mem_resp,
    output lc3b_arb_state state,
    output logic          grant,
    output lc3b_arb_owner grant_owner,
    output logic          conflict_inc,
    output logic          i_resp,
    output logic          d_resp
);

    lc3b_arb_state next_state;
    lc3b_arb_owner last_owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            last_owner <= D_FIRST ? ARB_OWNER_I : ARB_OWNER_D;
        end else begin
            state <= next_state;
            if (grant) begin
                last_owner <= grant_owner;
            end
        end
    end

    always_comb begin
        next_state   = state;
        grant        = 1'b0;
        grant_owner  = ARB_OWNER_I;
        conflict_inc = 1'b0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;

        case (state)
            ARB_IDLE: begin
                // A tie goes to whoever was not served last, so neither L1 can starve.
                if (i_pend && d_pend) begin
                    conflict_inc = 1'b1;
                    grant        = 1'b1;
                    grant_owner  = (last_owner == ARB_OWNER_I) ? ARB_OWNER_D : ARB_OWNER_I;
                end else if (i_pend) begin
                    grant       = 1'b1;
                    grant_owner = ARB_OWNER_I;
                end else if (d_pend) begin
                    grant       = 1'b1;
                    grant_owner = ARB_OWNER_D;
                end
                if (grant) begin
                    next_state = (grant_owner == ARB_OWNER_D) ? ARB_SERVE_D : ARB_SERVE_I;
                end
            end
            ARB_SERVE_I: begin
                i_resp = mem_resp;
                if (mem_resp) begin
                    next_state = ARB_IDLE;
                end
            end
            ARB_SERVE_D: begin
                d_resp = mem_resp;
                if (mem_resp) begin
                    next_state = ARB_IDLE;
                end
            end
            default: begin
                next_state = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/l2_arbiter.sv
// L2 port initiator front-end: merges I-cache and D-cache line traffic onto one
// hold-until-resp L2 interface, latching the winning request for its whole lifetime.
module l2_arbiter
    import lc3b_types::*;
#(
    parameter bit D_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_read,
    input  lc3b_word      i_address,
    output logic          i_resp,
    output lc3b_cacheline i_rdata,
    input  logic          d_read,
    input  logic          d_write,
    input  lc3b_word      d_address,
    input  lc3b_cacheline d_wdata,
    output logic          d_resp,
    output lc3b_cacheline d_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output lc3b_word      mem_address,
    output lc3b_cacheline mem_wdata,
    input  logic          mem_resp,
    input  lc3b_cacheline mem_rdata,
    output logic          conflict_inc
);

    lc3b_arb_state state;
    lc3b_arb_owner grant_owner;
    logic          grant;
    logic          serving;
    logic          lat_write;
    lc3b_word      lat_address;
    lc3b_cacheline lat_wdata;

    l2_arbiter_control #(
        .D_FIRST (D_FIRST)
    ) u_control (
        .clk          (clk),
        .rst          (rst),
        .i_pend       (i_read),
        .d_pend       (d_read | d_write),
        .mem_resp     (mem_resp),
        .state        (state),
        .grant        (grant),
        .grant_owner  (grant_owner),
        .conflict_inc (conflict_inc),
        .i_resp       (i_resp),
        .d_resp       (d_resp)
    );

    // The request is frozen at grant time; a D request with both op bits set is a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_write   <= 1'b0;
            lat_address <= '0;
            lat_wdata   <= '0;
        end else if (grant) begin
            if (grant_owner == ARB_OWNER_D) begin
                lat_write   <= d_write;
                lat_address <= d_address;
                lat_wdata   <= d_wdata;
            end else begin
                lat_write   <= 1'b0;
                lat_address <= i_address;
                lat_wdata   <= '0;
            end
        end
    end

    assign serving     = (state != ARB_IDLE);
    assign mem_read    = serving & ~lat_write;
    assign mem_write   = serving & lat_write;
    assign mem_address = serving ? lat_address : '0;
    assign mem_wdata   = serving ? lat_wdata : '0;

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_l2_arbiter;

    logic         clk;
    logic         rst;
    logic         i_read;
    logic [15:0]  i_address;
    logic         i_resp;
    logic [127:0] i_rdata;
    logic         d_read;
    logic         d_write;
    logic [15:0]  d_address;
    logic [127:0] d_wdata;
    logic         d_resp;
    logic [127:0] d_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [127:0] mem_wdata;
    logic         mem_resp;
    logic [127:0] mem_rdata;
    logic         conflict_inc;

    int checks = 0;
    int fails  = 0;

    l2_arbiter #(.D_FIRST(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_resp       (i_resp),
        .i_rdata      (i_rdata),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_resp       (d_resp),
        .d_rdata      (d_rdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_resp     (mem_resp),
        .mem_rdata    (mem_rdata),
        .conflict_inc (conflict_inc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_read    = 1'b0;
        i_address = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_address = '0;
        d_wdata   = '0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        sample();
        checks++;
        if ({mem_read, mem_write, i_resp, d_resp, conflict_inc} !== 5'b0) begin
            fails++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000", {mem_read, mem_write, i_resp, d_resp, conflict_inc});
        end
        checks++;
        if ({mem_address, mem_wdata} !== 144'h0) begin
            fails++;
            $display("[TB] FAIL reset_bus: got addr %h wdata %h expected 0", mem_address, mem_wdata);
        end
        tick();
    endtask

    task automatic test_i_only();
        i_read    = 1'b1;
        i_address = 16'h1230;
        sample();
        checks++;
        if (mem_read !== 1'b0) begin
            fails++;
            $display("[TB] FAIL i_only_latency: got mem_read %b expected 0", mem_read);
        end
        tick();
        sample();
        checks++;
        if ({mem_read, mem_write, mem_address} !== {2'b10, 16'h1230}) begin
            fails++;
            $display("[TB] FAIL i_only_request: got rd %b wr %b addr %h expected rd 1 wr 0 addr 1230", mem_read, mem_write, mem_address);
        end
        tick();
        tick();
        mem_resp  = 1'b1;
        mem_rdata = {16{8'hA5}};
        sample();
        checks++;
        if ({i_resp, d_resp, mem_read} !== 3'b101) begin
            fails++;
            $display("[TB] FAIL i_only_resp: got i_resp %b d_resp %b mem_read %b expected 1 0 1", i_resp, d_resp, mem_read);
        end
        checks++;
        if (i_rdata !== {16{8'hA5}}) begin
            fails++;
            $display("[TB] FAIL i_only_rdata: got %h expected a5..a5", i_rdata);
        end
        tick();
        mem_resp = 1'b0;
        i_read   = 1'b0;
        sample();
        checks++;
        if ({mem_read, i_resp} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL i_only_release: got mem_read %b i_resp %b expected 0 0", mem_read, i_resp);
        end
        tick();
    endtask

    task automatic test_d_write();
        d_write   = 1'b1;
        d_address = 16'h4440;
        d_wdata   = 128'h0123456789ABCDEF0123456789ABCDEF;
        tick();
        sample();
        checks++;
        if ({mem_write, mem_read, mem_address} !== {2'b10, 16'h4440}) begin
            fails++;
            $display("[TB] FAIL d_write_request: got wr %b rd %b addr %h expected wr 1 rd 0 addr 4440", mem_write, mem_read, mem_address);
        end
        checks++;
        if (mem_wdata !== 128'h0123456789ABCDEF0123456789ABCDEF) begin
            fails++;
            $display("[TB] FAIL d_write_wdata: got %h expected 0123456789abcdef0123456789abcdef", mem_wdata);
        end
        tick();
        mem_resp = 1'b1;
        sample();
        checks++;
        if ({d_resp, i_resp} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL d_write_resp: got d_resp %b i_resp %b expected 1 0", d_resp, i_resp);
        end
        tick();
        mem_resp = 1'b0;
        d_write  = 1'b0;
        sample();
        checks++;
        if (mem_write !== 1'b0) begin
            fails++;
            $display("[TB] FAIL d_write_release: got mem_write %b expected 0", mem_write);
        end
        tick();
    endtask

    task automatic test_conflict();
        logic        exp_d;
        logic [15:0] exp_addr;
        do_reset();
        i_read    = 1'b1;
        i_address = 16'h1110;
        d_read    = 1'b1;
        d_address = 16'h2220;
        sample();
        checks++;
        if ({conflict_inc, mem_read} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL conflict_first: got conflict %b mem_read %b expected 1 0", conflict_inc, mem_read);
        end
        for (int n = 0; n < 4; n++) begin
            exp_d    = (n % 2 == 0);
            exp_addr = exp_d ? 16'h2220 : 16'h1110;
            tick();
            sample();
            checks++;
            if ({mem_read, conflict_inc, mem_address} !== {2'b10, exp_addr}) begin
                fails++;
                $display("[TB] FAIL conflict_grant%0d: got rd %b conflict %b addr %h expected rd 1 conflict 0 addr %h", n, mem_read, conflict_inc, mem_address, exp_addr);
            end
            tick();
            mem_resp = 1'b1;
            sample();
            checks++;
            if ({d_resp, i_resp} !== {exp_d, ~exp_d}) begin
                fails++;
                $display("[TB] FAIL conflict_resp%0d: got d_resp %b i_resp %b expected %b %b", n, d_resp, i_resp, exp_d, ~exp_d);
            end
            tick();
            mem_resp = 1'b0;
            sample();
            checks++;
            if ({mem_read, conflict_inc} !== 2'b01) begin
                fails++;
                $display("[TB] FAIL conflict_gap%0d: got mem_read %b conflict %b expected 0 1", n, mem_read, conflict_inc);
            end
        end
        i_read = 1'b0;
        d_read = 1'b0;
        tick();
    endtask

    task automatic test_mid_change();
        d_read    = 1'b1;
        d_address = 16'h2000;
        tick();
        sample();
        checks++;
        if (mem_address !== 16'h2000) begin
            fails++;
            $display("[TB] FAIL mid_change_grant: got addr %h expected 2000", mem_address);
        end
        tick();
        d_address = 16'hFFF0;
        d_read    = 1'b0;
        sample();
        checks++;
        if ({mem_read, mem_address} !== {1'b1, 16'h2000}) begin
            fails++;
            $display("[TB] FAIL mid_change_hold: got rd %b addr %h expected rd 1 addr 2000", mem_read, mem_address);
        end
        tick();
        mem_resp = 1'b1;
        sample();
        checks++;
        if ({d_resp, mem_address} !== {1'b1, 16'h2000}) begin
            fails++;
            $display("[TB] FAIL mid_change_resp: got d_resp %b addr %h expected 1 2000", d_resp, mem_address);
        end
        tick();
        mem_resp = 1'b0;
        sample();
        checks++;
        if (mem_read !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mid_change_release: got mem_read %b expected 0", mem_read);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        i_read    = 1'b1;
        i_address = 16'h3330;
        tick();
        sample();
        checks++;
        if (mem_read !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_mid_grant: got mem_read %b expected 1", mem_read);
        end
        tick();
        rst    = 1'b1;
        i_read = 1'b0;
        sample();
        checks++;
        if (i_resp !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_mid_noresp: got i_resp %b expected 0", i_resp);
        end
        tick();
        rst = 1'b0;
        sample();
        checks++;
        if ({mem_read, mem_write, i_resp} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL reset_mid_drop: got rd %b wr %b i_resp %b expected 0 0 0", mem_read, mem_write, i_resp);
        end
        tick();
        mem_resp = 1'b1;
        sample();
        checks++;
        if ({i_resp, d_resp} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL reset_mid_stray: got i_resp %b d_resp %b expected 0 0", i_resp, d_resp);
        end
        tick();
        mem_resp = 1'b0;
        sample();
        checks++;
        if ({mem_read, mem_write} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL reset_mid_idle: got rd %b wr %b expected 0 0", mem_read, mem_write);
        end
        tick();
    endtask

    task automatic test_spurious();
        mem_resp = 1'b1;
        sample();
        checks++;
        if ({i_resp, d_resp, mem_read, mem_write} !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL spurious_resp: got i_resp %b d_resp %b rd %b wr %b expected 0000", i_resp, d_resp, mem_read, mem_write);
        end
        tick();
        mem_resp  = 1'b0;
        d_read    = 1'b1;
        d_address = 16'h5550;
        sample();
        checks++;
        if ({mem_read, mem_write} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL spurious_idle: got rd %b wr %b expected 0 0", mem_read, mem_write);
        end
        tick();
        sample();
        checks++;
        if ({mem_read, mem_address} !== {1'b1, 16'h5550}) begin
            fails++;
            $display("[TB] FAIL spurious_regrant: got rd %b addr %h expected rd 1 addr 5550", mem_read, mem_address);
        end
        tick();
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        d_read   = 1'b0;
        tick();
    endtask

    // Transaction-level model: who owns the port, what it asked for, and who was served last.
    task automatic test_random();
        int           owner;
        int           last;
        logic         t_write;
        logic [15:0]  t_addr;
        logic [127:0] t_wdata;
        logic         exp_conf;
        logic         exp_ir;
        logic         exp_dr;
        logic         i_pend;
        logic         d_pend;
        int           op;
        do_reset();
        idle_inputs();
        owner   = 0;
        last    = 1;
        t_write = 1'b0;
        t_addr  = '0;
        t_wdata = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!i_read && $urandom_range(0, 2) == 0) begin
                i_read    = 1'b1;
                i_address = 16'($urandom);
            end
            if (!(d_read || d_write) && $urandom_range(0, 2) == 0) begin
                op        = $urandom_range(0, 4);
                d_read    = (op < 2) || (op == 4);
                d_write   = (op >= 2);
                d_address = 16'($urandom);
                d_wdata   = {$urandom, $urandom, $urandom, $urandom};
            end
            mem_resp  = ($urandom_range(0, 3) == 0);
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            sample();

            i_pend   = i_read;
            d_pend   = d_read || d_write;
            exp_conf = (owner == 0) && i_pend && d_pend;
            exp_ir   = (owner == 1) && mem_resp;
            exp_dr   = (owner == 2) && mem_resp;

            checks++;
            if ({conflict_inc, i_resp, d_resp} !== {exp_conf, exp_ir, exp_dr}) begin
                fails++;
                $display("[TB] FAIL rand_ctrl cyc %0d: got conf/i_resp/d_resp %b expected %b", cyc, {conflict_inc, i_resp, d_resp}, {exp_conf, exp_ir, exp_dr});
            end
            checks++;
            if ({mem_read, mem_write} !== {(owner != 0) && !t_write, (owner != 0) && t_write}) begin
                fails++;
                $display("[TB] FAIL rand_op cyc %0d: got rd/wr %b expected %b", cyc, {mem_read, mem_write}, {(owner != 0) && !t_write, (owner != 0) && t_write});
            end
            if (owner != 0) begin
                checks++;
                if (mem_address !== t_addr) begin
                    fails++;
                    $display("[TB] FAIL rand_addr cyc %0d: got %h expected %h", cyc, mem_address, t_addr);
                end
            end
            if (owner == 2 && t_write) begin
                checks++;
                if (mem_wdata !== t_wdata) begin
                    fails++;
                    $display("[TB] FAIL rand_wdata cyc %0d: got %h expected %h", cyc, mem_wdata, t_wdata);
                end
            end
            if (exp_ir || exp_dr) begin
                checks++;
                if ((exp_ir ? i_rdata : d_rdata) !== mem_rdata) begin
                    fails++;
                    $display("[TB] FAIL rand_rdata cyc %0d: got %h expected %h", cyc, exp_ir ? i_rdata : d_rdata, mem_rdata);
                end
            end

            if (owner != 0) begin
                if (mem_resp) owner = 0;
            end else if (i_pend || d_pend) begin
                if (i_pend && d_pend) owner = (last == 1) ? 2 : 1;
                else                  owner = i_pend ? 1 : 2;
                last = owner;
                if (owner == 2) begin
                    t_write = d_write;
                    t_addr  = d_address;
                    t_wdata = d_wdata;
                end else begin
                    t_write = 1'b0;
                    t_addr  = i_address;
                    t_wdata = '0;
                end
            end

            tick();
            if (exp_ir) i_read = 1'b0;
            if (exp_dr) begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_i_only();
        test_d_write();
        test_conflict();
        test_mid_change();
        test_reset_mid();
        test_spurious();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
